fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, a single-entry output slot
// toward decode, and redirect handling. Define FETCH_SEQ_TIMEOUT_EN to add the response watchdog.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        fetch_err_out
);

    typedef enum logic [1:0] {RST, REQ, WAIT, DISCARD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] instr_n, pc_n;
    logic        valid_n;
    logic        timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign imem_req_out  = (state == REQ) && (!instr_valid_out || !stall_in);
    assign imem_addr_out = {fetch_pc[31:2], 2'b00};
    assign flush_out     = !instr_valid_out || redirect_in;

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
    logic       in_wait;

    assign in_wait = (state == WAIT) || (state == DISCARD);
    assign timeout = in_wait && (wd_cnt == WD_LAST);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            wd_cnt        <= 8'd0;
            fetch_err_out <= 1'b0;
        end else begin
            wd_cnt <= (in_wait && state_n != REQ) ? wd_cnt + 8'd1 : 8'd0;
            // A response or redirect arriving on the deadline cycle wins over the timeout.
            if (timeout && !redirect_in && !imem_rvalid_in)
                fetch_err_out <= 1'b1;
        end
    end
`else
    assign timeout       = 1'b0;
    assign fetch_err_out = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        valid_n    = instr_valid_out && stall_in;
        instr_n    = instr_out;
        pc_n       = pc_out;
        if (redirect_in) begin
            fetch_pc_n = redirect_pc_in;
            valid_n    = 1'b0;
            // Anything already granted must have its response swallowed in DISCARD.
            unique case (state)
                RST:     state_n = REQ;
                REQ:     state_n = (imem_req_out && imem_gnt_in) ? DISCARD : REQ;
                WAIT:    state_n = imem_rvalid_in ? REQ : DISCARD;
                DISCARD: state_n = DISCARD;
                default: state_n = REQ;
            endcase
        end else begin
            unique case (state)
                RST:  state_n = REQ;
                REQ:  if (imem_req_out && imem_gnt_in) state_n = WAIT;
                WAIT: begin
                    if (imem_rvalid_in) begin
                        instr_n    = imem_rdata_in;
                        pc_n       = fetch_pc;
                        valid_n    = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = REQ;
                    end else if (timeout) begin
                        state_n = REQ;
                    end
                end
                DISCARD: if (imem_rvalid_in || timeout) state_n = REQ;
                default: state_n = REQ;
            endcase
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state           <= RST;
            fetch_pc        <= RESET_PC;
            instr_valid_out <= 1'b0;
            instr_out       <= 32'h0000_0013;
            pc_out          <= RESET_PC;
        end else begin
            state           <= state_n;
            fetch_pc        <= fetch_pc_n;
            instr_valid_out <= valid_n;
            instr_out       <= instr_n;
            pc_out          <= pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; timeout expectations follow FETCH_SEQ_TIMEOUT_EN.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, stall;
    logic [31:0] redirect_pc;
    logic        instr_valid, flush, fetch_err;
    logic [31:0] instr, pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(10)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .imem_req_out(imem_req),
        .imem_addr_out(imem_addr),
        .imem_gnt_in(imem_gnt),
        .imem_rvalid_in(imem_rvalid),
        .imem_rdata_in(imem_rdata),
        .redirect_in(redirect),
        .redirect_pc_in(redirect_pc),
        .stall_in(stall),
        .instr_valid_out(instr_valid),
        .instr_out(instr),
        .pc_out(pc),
        .flush_out(flush),
        .fetch_err_out(fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'd1);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // one RST cycle after release, then the first request
        rst = 1'b0; #1;
        chk("rst_state_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0; #1;
        chk("wait_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093; tick(); imem_rvalid = 1'b0; #1;
        chk("d0_valid", 32'(instr_valid), 32'd1);
        chk("d0_instr", instr, 32'h0010_0093);
        chk("d0_pc", pc, 32'h0);
        chk("d0_flush", 32'(flush), 32'd0);
        chk("next_addr", imem_addr, 32'h4);

        // stall with slot occupied: no request, output held
        stall = 1'b1; #1;
        chk("stall_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            imem_gnt = 1'b1; tick(); imem_gnt = 1'b0; #1;
            chk("stall_instr", instr, 32'h0010_0093);
            chk("stall_pc", pc, 32'h0);
            chk("stall_req_hold", 32'(imem_req), 32'd0);
        end
        stall = 1'b0; #1;
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, 32'h4);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0; #1;
        chk("consumed_valid", 32'(instr_valid), 32'd0);
        chk("consumed_flush", 32'(flush), 32'd1);
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_0113; tick(); imem_rvalid = 1'b0; #1;
        chk("d1_instr", instr, 32'h0020_0113);
        chk("d1_pc", pc, 32'h4);
        chk("d1_next_addr", imem_addr, 32'h8);

        // redirect while waiting: response dropped in DISCARD
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0; #1;
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        chk("redir_flush", 32'(flush), 32'd1);
        tick(); redirect = 1'b0; #1;
        chk("discard_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0; #1;
        chk("discard_valid", 32'(instr_valid), 32'd0);
        chk("discard_instr", instr, 32'h0020_0113);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h200);

        // redirect coincident with rvalid in WAIT
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h300; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        tick(); redirect = 1'b0; imem_rvalid = 1'b0; #1;
        chk("coinc_valid", 32'(instr_valid), 32'd0);
        chk("coinc_instr", instr, 32'h0020_0113);
        chk("coinc_req", 32'(imem_req), 32'd1);
        chk("coinc_addr", imem_addr, 32'h300);

        // address wrap at top of memory
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 1'b0; #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; tick(); imem_rvalid = 1'b0; #1;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_addr1", imem_addr, 32'h0);

        // redirect with grant in REQ, then redirect again inside DISCARD
        imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h400; tick();
        imem_gnt = 1'b0; redirect_pc = 32'h500; #1;
        chk("rg_req", 32'(imem_req), 32'd0);
        chk("rg_valid", 32'(instr_valid), 32'd0);
        tick(); redirect = 1'b0; #1;
        chk("rd_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; tick(); imem_rvalid = 1'b0; #1;
        chk("rd_addr", imem_addr, 32'h500);
        chk("rd_valid", 32'(instr_valid), 32'd0);

        // watchdog: grant, no response
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("wd_pre_err", 32'(fetch_err), 32'd0);
        chk("wd_pre_req", 32'(imem_req), 32'd0);
        tick();
`ifdef FETCH_SEQ_TIMEOUT_EN
        chk("wd_err", 32'(fetch_err), 32'd1);
        chk("wd_req", 32'(imem_req), 32'd1);
        chk("wd_addr", imem_addr, 32'h500);
        tick();
        chk("wd_sticky", 32'(fetch_err), 32'd1);
`else
        chk("wd_err", 32'(fetch_err), 32'd0);
        chk("wd_req", 32'(imem_req), 32'd0);
`endif

        // reset mid-transaction, late response ignored
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("rst2_err", 32'(fetch_err), 32'd0);
        chk("rst2_req", 32'(imem_req), 32'd0);
        chk("rst2_instr", instr, 32'h0000_0013);
        imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; tick(); imem_rvalid = 1'b0; #1;
        chk("late_valid", 32'(instr_valid), 32'd0);
        chk("late_req", 32'(imem_req), 32'd1);
        chk("late_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
